// File: rtl/pong_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : pong_engine_if
// Brief    : Video-timing, button and pixel-output bundle for the game-object
//            stage. The master side drives timing/buttons, the engine (slave)
//            returns colour, miss count and the frame tick.
// Revision : 1.0 - initial release
// ============================================================================
interface pong_engine_if;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [9:0] x_loc;
    logic [9:0] y_loc;
    logic       video_on;
    logic       btn_up;
    logic       btn_dn;
    logic       btn_serve;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic [3:0] miss_count;
    logic       frame_tick;

    modport master (
        output h_count, v_count, x_loc, y_loc, video_on,
        output btn_up, btn_dn, btn_serve,
        input  red, green, blue, miss_count, frame_tick
    );

    modport slave (
        input  h_count, v_count, x_loc, y_loc, video_on,
        input  btn_up, btn_dn, btn_serve,
        output red, green, blue, miss_count, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/pong_engine.sv
`default_nettype none
// ============================================================================
// Module   : pong_engine
// Brief    : Ball/paddle game stage. Synchronises the buttons, keeps ball and
//            paddle state (updated once per frame in vertical blanking), runs
//            the serve/run/miss FSM and renders the registered 4-bit RGB pixel.
// Revision : 1.0 - initial release
// ============================================================================
module pong_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_X    = 16,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int BALL_SPEED  = 2,
    parameter int PADDLE_STEP = 4,
    parameter int MISS_HOLD   = 60
) (
    input  logic         clk,
    input  logic         rst_n,
    pong_engine_if.slave bus
);

    // FSM encoding
    localparam logic [1:0] c_st_serve = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_miss  = 2'd2;

    // All geometry is evaluated in 11 bits so sums never wrap
    localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_active   = 11'(V_ACTIVE);
    localparam logic [10:0] c_size       = 11'(BALL_SIZE);
    localparam logic [10:0] c_speed      = 11'(BALL_SPEED);
    localparam logic [10:0] c_step       = 11'(PADDLE_STEP);
    localparam logic [10:0] c_paddle_x   = 11'(PADDLE_X);
    localparam logic [10:0] c_paddle_r   = 11'(PADDLE_X + PADDLE_W);
    localparam logic [10:0] c_paddle_h   = 11'(PADDLE_H);
    localparam logic [10:0] c_paddle_max = 11'(V_ACTIVE - PADDLE_H);
    localparam logic [10:0] c_border     = 11'd4;
    localparam logic [9:0]  c_ball_x0    = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  c_ball_y0    = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  c_paddle_y0  = 10'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [9:0]  c_tick_line  = 10'(V_ACTIVE);

    localparam int                  c_hold_w   = $clog2(MISS_HOLD + 1);
    localparam logic [c_hold_w-1:0] c_hold_ld  = c_hold_w'(MISS_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

    logic [1:0]          r_up_sync;
    logic [1:0]          r_dn_sync;
    logic [1:0]          r_srv_sync;
    logic                r_srv_prev;
    logic                r_frame_tick;
    logic [9:0]          r_ball_x;
    logic [9:0]          r_ball_y;
    logic                r_dir_right;
    logic                r_dir_down;
    logic [9:0]          r_paddle_y;
    logic [1:0]          r_state;
    logic [c_hold_w-1:0] r_hold;
    logic [3:0]          r_miss_count;
    logic [11:0]         r_rgb;

    logic        w_up;
    logic        w_dn;
    logic        w_serve_edge;
    logic [10:0] w_ball_x;
    logic [10:0] w_ball_y;
    logic [10:0] w_paddle;
    logic [10:0] w_paddle_next;
    logic [10:0] w_next_x;
    logic [10:0] w_next_y;
    logic        w_next_right;
    logic        w_next_down;
    logic        w_hit;
    logic        w_miss;
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic        w_in_ball;
    logic        w_in_paddle;
    logic        w_in_border;
    logic [11:0] w_rgb;
    logic        w_unused_msb;

    assign w_up         = r_up_sync[1];
    assign w_dn         = r_dn_sync[1];
    assign w_serve_edge = r_srv_sync[1] & ~r_srv_prev;
    assign w_ball_x     = {1'b0, r_ball_x};
    assign w_ball_y     = {1'b0, r_ball_y};
    assign w_paddle     = {1'b0, r_paddle_y};
    assign w_px         = {1'b0, bus.x_loc};
    assign w_py         = {1'b0, bus.y_loc};
    assign w_unused_msb = ^{w_next_x[10], w_next_y[10], w_paddle_next[10]};

    // Two-flop synchronisers for the asynchronous buttons, plus serve edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_sync  <= 2'b00;
            r_dn_sync  <= 2'b00;
            r_srv_sync <= 2'b00;
            r_srv_prev <= 1'b0;
        end else begin
            r_up_sync  <= {r_up_sync[0], bus.btn_up};
            r_dn_sync  <= {r_dn_sync[0], bus.btn_dn};
            r_srv_sync <= {r_srv_sync[0], bus.btn_serve};
            r_srv_prev <= r_srv_sync[1];
        end
    end

    // Frame tick lands in vertical blanking, the cycle after the first blank line starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= (bus.h_count == 10'd0) && (bus.v_count == c_tick_line);
        end
    end

    // Paddle target: one step per frame, clamped to the visible height
    always_comb begin
        w_paddle_next = w_paddle;
        if (w_up && !w_dn) begin
            w_paddle_next = (w_paddle <= c_step) ? 11'd0 : (w_paddle - c_step);
        end else if (w_dn && !w_up) begin
            w_paddle_next = (w_paddle + c_step >= c_paddle_max) ? c_paddle_max
                                                                : (w_paddle + c_step);
        end
    end

    // Candidate ball step: wall bounces, paddle return or miss detection
    always_comb begin
        w_next_x     = w_ball_x;
        w_next_y     = w_ball_y;
        w_next_right = r_dir_right;
        w_next_down  = r_dir_down;
        w_hit        = 1'b0;
        w_miss       = 1'b0;

        if (r_dir_down) begin
            if (w_ball_y + c_size + c_speed >= c_v_active) begin
                w_next_y    = c_v_active - c_size;
                w_next_down = 1'b0;
            end else begin
                w_next_y = w_ball_y + c_speed;
            end
        end else begin
            if (w_ball_y <= c_speed) begin
                w_next_y    = 11'd0;
                w_next_down = 1'b1;
            end else begin
                w_next_y = w_ball_y - c_speed;
            end
        end

        if (r_dir_right) begin
            if (w_ball_x + c_size + c_speed >= c_h_active) begin
                w_next_x     = c_h_active - c_size;
                w_next_right = 1'b0;
            end else begin
                w_next_x = w_ball_x + c_speed;
            end
        end else begin
            // Paddle face is crossed this frame while the ball overlaps it vertically
            w_hit = (w_ball_x >= c_paddle_r) && (w_ball_x < c_paddle_r + c_speed) &&
                    (w_ball_y + c_size > w_paddle) && (w_ball_y < w_paddle + c_paddle_h);
            if (w_hit) begin
                w_next_x     = c_paddle_r;
                w_next_right = 1'b1;
            end else if (w_ball_x <= c_speed) begin
                w_miss = 1'b1;
            end else begin
                w_next_x = w_ball_x - c_speed;
            end
        end
    end

    // Game state: paddle every frame, ball per FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_paddle_y   <= c_paddle_y0;
            r_ball_x     <= c_ball_x0;
            r_ball_y     <= c_ball_y0;
            r_dir_right  <= 1'b1;
            r_dir_down   <= 1'b1;
            r_state      <= c_st_serve;
            r_hold       <= '0;
            r_miss_count <= 4'd0;
        end else begin
            if (r_frame_tick) begin
                r_paddle_y <= w_paddle_next[9:0];
            end
            case (r_state)
                c_st_serve: begin
                    if (w_serve_edge) begin
                        r_state     <= c_st_run;
                        r_dir_right <= 1'b1;
                        r_dir_down  <= 1'b1;
                    end
                end
                c_st_run: begin
                    if (r_frame_tick) begin
                        if (w_miss) begin
                            // Ball freezes where it left the field
                            r_state <= c_st_miss;
                            r_hold  <= c_hold_ld;
                            if (r_miss_count != 4'hF) begin
                                r_miss_count <= r_miss_count + 4'd1;
                            end
                        end else begin
                            r_ball_x    <= w_next_x[9:0];
                            r_ball_y    <= w_next_y[9:0];
                            r_dir_right <= w_next_right;
                            r_dir_down  <= w_next_down;
                        end
                    end
                end
                c_st_miss: begin
                    if (r_frame_tick) begin
                        if (r_hold <= c_hold_one) begin
                            r_hold      <= '0;
                            r_ball_x    <= c_ball_x0;
                            r_ball_y    <= c_ball_y0;
                            r_dir_right <= 1'b1;
                            r_dir_down  <= 1'b1;
                            r_state     <= c_st_serve;
                        end else begin
                            r_hold <= r_hold - c_hold_one;
                        end
                    end
                end
                default: r_state <= c_st_serve;
            endcase
        end
    end

    // Pixel colour by priority: blanking, ball, paddle, top/bottom border
    always_comb begin
        w_in_ball   = (w_px >= w_ball_x) && (w_px < w_ball_x + c_size) &&
                      (w_py >= w_ball_y) && (w_py < w_ball_y + c_size);
        w_in_paddle = (w_px >= c_paddle_x) && (w_px < c_paddle_r) &&
                      (w_py >= w_paddle) && (w_py < w_paddle + c_paddle_h);
        w_in_border = (w_py < c_border) || (w_py >= c_v_active - c_border);
        w_rgb       = 12'h000;
        if (!bus.video_on) begin
            w_rgb = 12'h000;
        end else if (w_in_ball) begin
            w_rgb = 12'hFFF;
        end else if (w_in_paddle) begin
            w_rgb = 12'h0F0;
        end else if (w_in_border) begin
            w_rgb = 12'h008;
        end
    end

    // One output register stage for the pixel colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= 12'h000;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign bus.red        = r_rgb[11:8];
    assign bus.green      = r_rgb[7:4];
    assign bus.blue       = r_rgb[3:0];
    assign bus.miss_count = r_miss_count;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_pong_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_engine
// Brief    : Self-checking bench for pong_engine. Frames are compressed to a
//            few cycles (only h_count==0/v_count==V_ACTIVE matters for the
//            tick); a frame-level game model predicts pixels and miss count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_engine;

    localparam int H = 640;
    localparam int V = 480;
    localparam int S = 8;
    localparam int SP = 2;
    localparam int PX = 16;
    localparam int PW = 8;
    localparam int PH = 64;
    localparam int STEP = 4;
    localparam int HOLD = 60;
    localparam int M_SERVE = 0;
    localparam int M_RUN = 1;
    localparam int M_MISS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Frame-level game model
    int m_bx, m_by, m_vx, m_vy, m_py, m_mode, m_hold, m_misses;
    bit m_prev_srv;

    always #5 clk = ~clk;

    pong_engine_if bus ();

    pong_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #950000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_bx = (H - S) / 2;
        m_by = (V - S) / 2;
        m_vx = SP;
        m_vy = SP;
        m_py = (V - PH) / 2;
        m_mode = M_SERVE;
        m_hold = 0;
        m_misses = 0;
        m_prev_srv = 1'b0;
    endfunction

    function automatic void model_frame(input bit up, input bit dn, input bit srv);
        int old_py, nx, ny, nvx, nvy;
        bit missed;
        if (srv && !m_prev_srv && m_mode == M_SERVE) begin
            m_mode = M_RUN;
            m_vx = SP;
            m_vy = SP;
        end
        m_prev_srv = srv;
        old_py = m_py;
        if (up && !dn) m_py = (m_py - STEP < 0) ? 0 : m_py - STEP;
        if (dn && !up) m_py = (m_py + STEP > V - PH) ? V - PH : m_py + STEP;
        if (m_mode == M_RUN) begin
            missed = 1'b0;
            ny = m_by + m_vy;
            nvy = m_vy;
            if (m_vy < 0 && ny <= 0) begin
                ny = 0; nvy = SP;
            end else if (m_vy > 0 && ny + S >= V) begin
                ny = V - S; nvy = -SP;
            end
            nx = m_bx + m_vx;
            nvx = m_vx;
            if (m_vx > 0) begin
                if (nx + S >= H) begin nx = H - S; nvx = -SP; end
            end else if (m_bx >= PX + PW && nx < PX + PW &&
                         m_by + S > old_py && m_by < old_py + PH) begin
                nx = PX + PW; nvx = SP;
            end else if (nx <= 0) begin
                missed = 1'b1;
            end
            if (missed) begin
                m_misses++;
                m_mode = M_MISS;
                m_hold = HOLD;
            end else begin
                m_bx = nx; m_by = ny; m_vx = nvx; m_vy = nvy;
            end
        end else if (m_mode == M_MISS) begin
            m_hold--;
            if (m_hold == 0) begin
                m_bx = (H - S) / 2;
                m_by = (V - S) / 2;
                m_mode = M_SERVE;
            end
        end
    endfunction

    function automatic logic [11:0] exp_pix(input int x, input int y, input bit von);
        if (!von) return 12'h000;
        if (x >= m_bx && x < m_bx + S && y >= m_by && y < m_by + S) return 12'hFFF;
        if (x >= PX && x < PX + PW && y >= m_py && y < m_py + PH) return 12'h0F0;
        if (y < 4 || y >= V - 4) return 12'h008;
        return 12'h000;
    endfunction

    // Called and returns at a negedge; one frame = 3 idle cycles, tick trigger, update
    task automatic run_frame(input bit up, input bit dn, input bit srv);
        int pulses;
        pulses = 0;
        bus.btn_up = up;
        bus.btn_dn = dn;
        bus.btn_serve = srv;
        bus.h_count = 10'd5;
        bus.v_count = 10'd100;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            pulses += int'(bus.frame_tick);
        end
        bus.h_count = 10'd0;
        bus.v_count = 10'(V);
        @(posedge clk);
        @(negedge clk);
        check("frame_tick_at_tick", {31'd0, bus.frame_tick}, 32'd1);
        pulses += int'(bus.frame_tick);
        bus.h_count = 10'd5;
        bus.v_count = 10'd100;
        @(posedge clk);
        @(negedge clk);
        pulses += int'(bus.frame_tick);
        model_frame(up, dn, srv);
        check("frame_tick_pulses", pulses, 1);
        check("miss_count", {28'd0, bus.miss_count}, (m_misses > 15) ? 15 : m_misses);
    endtask

    task automatic probe(input int x, input int y, input bit von, input logic [11:0] exp,
                         input string tag);
        bus.x_loc = 10'(x);
        bus.y_loc = 10'(y);
        bus.video_on = von;
        @(posedge clk);
        @(negedge clk);
        check(tag, {20'd0, bus.red, bus.green, bus.blue}, {20'd0, exp});
    endtask

    task automatic mprobe(input int x, input int y, input bit von, input string tag);
        probe(x, y, von, exp_pix(x, y, von), tag);
    endtask

    task automatic probe_model();
        int px, py, rx, ry;
        bit rv;
        mprobe(m_bx, m_by, 1'b1, "ball_tl");
        mprobe(m_bx + S - 1, m_by + S - 1, 1'b1, "ball_br");
        mprobe(m_bx + S, m_by, 1'b1, "ball_right_out");
        if (m_by > 0) mprobe(m_bx, m_by - 1, 1'b1, "ball_above");
        if (m_bx > 0) mprobe(m_bx - 1, m_by + 3, 1'b1, "ball_left_out");
        px = PX + int'($urandom_range(0, PW - 1));
        py = m_py + int'($urandom_range(0, PH - 1));
        mprobe(px, py, 1'b1, "paddle_in");
        mprobe(PX + PW, m_py, 1'b1, "paddle_right_out");
        if (m_py + PH < V) mprobe(PX, m_py + PH, 1'b1, "paddle_below");
        rx = int'($urandom_range(0, H - 1));
        ry = int'($urandom_range(0, V - 1));
        rv = 1'($urandom_range(0, 1));
        mprobe(rx, ry, rv, "random_px");
    endtask

    initial begin
        int frames;
        bit s;
        bit last_srv;

        bus.h_count = 10'd5;
        bus.v_count = 10'd100;
        bus.x_loc = 10'd0;
        bus.y_loc = 10'd0;
        bus.video_on = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        bus.btn_serve = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_red", {28'd0, bus.red}, 32'd0);
        check("reset_green", {28'd0, bus.green}, 32'd0);
        check("reset_blue", {28'd0, bus.blue}, 32'd0);
        check("reset_miss", {28'd0, bus.miss_count}, 32'd0);
        check("reset_tick", {31'd0, bus.frame_tick}, 32'd0);
        rst_n = 1'b1;

        // Idle frames: ball parked at centre, paddle at reset height
        run_frame(0, 0, 0);
        run_frame(0, 0, 0);
        probe(316, 236, 1'b1, 12'hFFF, "centre_tl");
        probe(323, 243, 1'b1, 12'hFFF, "centre_br");
        probe(324, 236, 1'b1, 12'h000, "centre_right_out");
        probe(316, 244, 1'b1, 12'h000, "centre_below_out");
        probe(16, 208, 1'b1, 12'h0F0, "paddle_reset_top");
        probe(16, 207, 1'b1, 12'h000, "paddle_reset_above");

        // Serve then nine more frames: ten ticks of motion
        run_frame(0, 0, 1);
        repeat (9) run_frame(0, 0, 0);
        probe(336, 256, 1'b1, 12'hFFF, "served_tl");
        probe(343, 263, 1'b1, 12'hFFF, "served_br");
        probe(335, 256, 1'b1, 12'h000, "served_left_out");
        probe(336, 256, 1'b0, 12'h000, "blank_on_ball");
        probe(100, 2, 1'b1, 12'h008, "border_top");
        probe(100, 477, 1'b1, 12'h008, "border_bottom");

        // Paddle pinned at the top, then both buttons hold it
        repeat (60) run_frame(1, 0, 0);
        probe(16, 0, 1'b1, 12'h0F0, "paddle_clamp_top");
        probe(23, 63, 1'b1, 12'h0F0, "paddle_clamp_bottom_row");
        probe(16, 64, 1'b1, 12'h000, "paddle_clamp_below");
        probe(24, 0, 1'b1, 12'h008, "paddle_right_border");
        repeat (5) run_frame(1, 1, 0);
        probe(16, 0, 1'b1, 12'h0F0, "paddle_both_top");
        probe(16, 64, 1'b1, 12'h000, "paddle_both_below");
        probe_model();

        // Random buttons against the model
        for (int i = 0; i < 500; i++) begin
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0));
            probe_model();
        end

        // Asynchronous reset between clock edges
        probe(m_bx, m_by, 1'b1, exp_pix(m_bx, m_by, 1'b1), "pre_reset_ball");
        #2;
        rst_n = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        bus.btn_serve = 1'b0;
        #1;
        check("async_reset_rgb", {20'd0, bus.red, bus.green, bus.blue}, 32'd0);
        check("async_reset_miss", {28'd0, bus.miss_count}, 32'd0);
        check("async_reset_tick", {31'd0, bus.frame_tick}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 0, 0);
        probe(316, 236, 1'b1, 12'hFFF, "post_reset_centre");
        probe_model();

        // Paddle parked at top; serve whenever idle until sixteen misses
        frames = 0;
        last_srv = 1'b0;
        while (m_misses < 16 && frames < 14000) begin
            if (m_mode == M_SERVE) s = !last_srv;
            else s = ($urandom_range(0, 7) == 0);
            last_srv = s;
            run_frame(1, 0, s);
            frames++;
            if (frames % 64 == 0) probe_model();
        end
        if (m_misses < 16) begin
            total++;
            bad++;
            $error("FAIL miss_phase_budget observed=%0d misses required=16", m_misses);
        end
        check("miss_saturated", {28'd0, bus.miss_count}, 32'd15);

        // Serve edges during the hold are ignored; ball returns to centre
        for (int i = 0; i < HOLD; i++) begin
            last_srv = !last_srv;
            run_frame(1, 0, last_srv);
        end
        probe(316, 236, 1'b1, 12'hFFF, "miss_return_centre");
        probe(315, 236, 1'b1, 12'h000, "miss_return_left_out");
        run_frame(1, 0, last_srv);
        run_frame(1, 0, last_srv);
        probe(316, 236, 1'b1, 12'hFFF, "serve_waits_for_edge");
        probe_model();
        check("miss_still_saturated", {28'd0, bus.miss_count}, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
